// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: 2-bit counter states and the
// values used on reset and on allocation.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] CTR_ALLOC = WT;
  localparam logic [1:0] CTR_RESET = WNT;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next state of a 2-bit saturating taken/not-taken counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    if (taken) begin
      if (state != ST) next_state = state + 2'd1;
    end else begin
      if (state != SNT) next_state = state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, zero-cycle lookup
// from the registered table, single-cycle clear and saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              hit,
  output logic              predict_taken,
  output logic [PC_W-1:0]   predict_target,
  input  logic              update_valid,
  input  logic [PC_W-1:0]   update_pc,
  input  logic              update_taken,
  input  logic [PC_W-1:0]   update_target,
  input  logic              update_mispredict,
  input  logic              clear,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 1;
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, up_hit;
  logic [1:0]        up_ctr_next;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [STAT_W-1:0]  branch_q, branch_d;
  logic [STAT_W-1:0]  mispred_q, mispred_d;

  // Bit 0 of a PC carries no information with 2-byte aligned instructions.
  logic unused_pc_lsb;
  assign unused_pc_lsb = lookup_pc[0] ^ update_pc[0];

  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[PC_W-1:IDX_W+1];
  assign up_idx = update_pc[IDX_W:1];
  assign up_tag = update_pc[PC_W-1:IDX_W+1];

  // Lookup reads only registered state, so an update in the same cycle is not visible.
  assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign hit            = lk_hit;
  assign predict_taken  = lk_hit & ctr_q[lk_idx][1];
  assign predict_target = lk_hit ? target_q[lk_idx] : '0;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  bp_sat_counter u_sat_counter (
    .state      (ctr_q[up_idx]),
    .taken      (update_taken),
    .next_state (up_ctr_next)
  );

  // update_* is a valid-only interface: all update fields are sampled on the
  // rising edge where update_valid=1 and ignored otherwise; there is no backpressure.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (clear) begin
      valid_d = '0;
    end else if (update_valid) begin
      if (up_hit) begin
        ctr_d[up_idx] = up_ctr_next;
        if (update_taken) target_d[up_idx] = update_target;
      end else if (update_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target;
        ctr_d[up_idx]    = CTR_ALLOC;
      end
    end
  end

  // Statistics ignore clear and stick at all-ones.
  always_comb begin
    branch_d  = branch_q;
    mispred_d = mispred_q;
    if (update_valid) begin
      if (branch_q != '1) branch_d = branch_q + STAT_ONE;
      if (update_mispredict && (mispred_q != '1)) mispred_d = mispred_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      branch_q  <= '0;
      mispred_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      target_q  <= target_d;
      ctr_q     <= ctr_d;
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
    end
  end

  assign branch_count     = branch_q;
  assign mispredict_count = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a table model
// built from the prediction rules; a 4-bit-statistics instance shares the stimulus.
module tb_branch_predictor;

  localparam int PC_W    = 16;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [PC_W-1:0] lookup_pc = '0;
  logic            update_valid = 1'b0;
  logic [PC_W-1:0] update_pc = '0;
  logic            update_taken = 1'b0;
  logic [PC_W-1:0] update_target = '0;
  logic            update_mispredict = 1'b0;
  logic            clear = 1'b0;

  logic            hit, predict_taken;
  logic [PC_W-1:0] predict_target;
  logic [15:0]     branch_count, mispredict_count;
  logic            s_hit, s_predict_taken;
  logic [PC_W-1:0] s_predict_target;
  logic [3:0]      s_branch_count, s_mispredict_count;

  branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .hit(hit), .predict_taken(predict_taken), .predict_target(predict_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .clear(clear), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .STAT_W(4)) dut_s (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .hit(s_hit), .predict_taken(s_predict_taken), .predict_target(s_predict_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .clear(clear), .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  // ---------------- reference model ----------------
  bit m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_ctr   [ENTRIES];
  int m_branches;
  int m_mispredicts;

  int checks = 0;
  int errors = 0;
  logic [PC_W+1:0] exp_q[$];

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return (int'(pc) / 2) % ENTRIES;
  endfunction

  function automatic int tag_of(input logic [PC_W-1:0] pc);
    return int'(pc) / (2 * ENTRIES);
  endfunction

  // {hit, taken, target} the model predicts for pc
  function automatic logic [PC_W+1:0] model_lookup(input logic [PC_W-1:0] pc);
    int  i;
    bit  h;
    i = idx_of(pc);
    h = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (!h) return '0;
    return {1'b1, (m_ctr[i] >= 2), m_tgt[i][PC_W-1:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_branches = 0;
    m_mispredicts = 0;
  endtask

  task automatic model_apply(input logic uv, input logic [PC_W-1:0] upc, input logic ut,
                             input logic [PC_W-1:0] utg, input logic um, input logic clr);
    int  i;
    bit  h;
    if (uv) begin
      m_branches++;
      if (um) m_mispredicts++;
    end
    if (clr) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (uv) begin
      i = idx_of(upc);
      h = m_valid[i] && (m_tag[i] == tag_of(upc));
      if (h && ut) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = int'(utg);
      end else if (h) begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end else if (ut) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = int'(utg); m_ctr[i] = 2;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [PC_W+1:0] e;
    int sat16, sat4m, sat4b, sat16m;
    exp_q.push_back(model_lookup(lookup_pc));
    e = exp_q.pop_front();
    sat16  = (m_branches > 16'hFFFF) ? 16'hFFFF : m_branches;
    sat16m = (m_mispredicts > 16'hFFFF) ? 16'hFFFF : m_mispredicts;
    sat4b  = (m_branches > 15) ? 15 : m_branches;
    sat4m  = (m_mispredicts > 15) ? 15 : m_mispredicts;
    check({tag, ".hit"},    32'(hit),            32'(e[PC_W+1]));
    check({tag, ".taken"},  32'(predict_taken),  32'(e[PC_W]));
    check({tag, ".target"}, 32'(predict_target), 32'(e[PC_W-1:0]));
    check({tag, ".s_hit"},  32'({s_hit, s_predict_taken, s_predict_target}), 32'(e));
    check({tag, ".branch_count"},     32'(branch_count),       32'(sat16));
    check({tag, ".mispredict_count"}, 32'(mispredict_count),   32'(sat16m));
    check({tag, ".s_branch_count"},   32'(s_branch_count),     32'(sat4b));
    check({tag, ".s_mispredict"},     32'(s_mispredict_count), 32'(sat4m));
  endtask

  // ---------------- driver ----------------
  // One cycle: drive at negedge, check before the edge, advance the model at the edge.
  task automatic step(input string tag, input logic [PC_W-1:0] lpc, input logic uv,
                      input logic [PC_W-1:0] upc, input logic ut, input logic [PC_W-1:0] utg,
                      input logic um, input logic clr);
    @(negedge clk);
    lookup_pc = lpc; update_valid = uv; update_pc = upc; update_taken = ut;
    update_target = utg; update_mispredict = um; clear = clr;
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_apply(uv, upc, ut, utg, um, clr);
  endtask

  task automatic look(input string tag, input logic [PC_W-1:0] lpc);
    step(tag, lpc, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0);
  endtask

  task automatic upd(input string tag, input logic [PC_W-1:0] pc, input logic ut,
                     input logic [PC_W-1:0] utg);
    step(tag, pc, 1'b1, pc, ut, utg, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PC_W-1:0] pc, pc2;
    model_reset();
    lookup_pc = 16'h0040;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("in_reset");
    @(negedge clk);
    rst = 1'b0;

    look("reset_lookup_0040", 16'h0040);
    upd("alloc_0040", 16'h0040, 1'b1, 16'h0100);
    look("after_alloc", 16'h0040);
    check("alloc_target", 32'(predict_target), 32'h0100);
    upd("nt1", 16'h0040, 1'b0, 16'h0BAD);
    upd("nt2", 16'h0040, 1'b0, 16'h0BAD);
    look("after_two_nt", 16'h0040);
    check("two_nt_hit_not_taken", 32'({hit, predict_taken}), 32'h2);
    upd("t1", 16'h0040, 1'b1, 16'h0110);
    upd("t2", 16'h0040, 1'b1, 16'h0120);
    upd("t3", 16'h0040, 1'b1, 16'h0130);
    upd("nt_from_strong", 16'h0040, 1'b0, 16'h0BAD);
    look("still_taken", 16'h0040);
    check("strong_then_nt_taken", 32'({hit, predict_taken}), 32'h3);
    upd("alias_0060", 16'h0060, 1'b1, 16'h0200);
    look("alias_0040_miss", 16'h0040);
    look("alias_0060_hit", 16'h0060);
    look("odd_pc_bit0_ignored", 16'h0061);
    step("same_cycle_nobypass", 16'h0060, 1'b1, 16'h0060, 1'b1, 16'h0300, 1'b0, 1'b0);
    look("after_bypass_cycle", 16'h0060);
    step("idle_ignored", 16'h0060, 1'b0, 16'h0060, 1'b1, 16'h0777, 1'b1, 1'b0);
    look("idle_no_change", 16'h0060);
    step("clear_with_update", 16'h0060, 1'b1, 16'h0080, 1'b1, 16'h0400, 1'b1, 1'b1);
    look("cleared_0060", 16'h0060);
    look("cleared_0080", 16'h0080);

    for (int n = 0; n < 400; n++) begin
      pc  = 16'($urandom_range(0, 255));
      pc2 = ($urandom_range(0, 1) == 1) ? pc : 16'($urandom_range(0, 255));
      step("rand", pc2, ($urandom_range(0, 3) != 0), pc, 1'($urandom),
           16'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));
    end

    // Reset landing in the middle of an update cycle discards the update.
    @(negedge clk);
    lookup_pc = 16'h00A0; update_valid = 1'b1; update_pc = 16'h00A0;
    update_taken = 1'b1; update_target = 16'h0555; update_mispredict = 1'b1; clear = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    check_outputs("reset_held_edge");
    @(negedge clk);
    rst = 1'b0;
    update_valid = 1'b0;
    look("resume_miss", 16'h00A0);
    upd("resume_alloc", 16'h00A0, 1'b1, 16'h0666);
    look("resume_hit", 16'h00A0);

    for (int n = 0; n < 20; n++)
      step("stat_sat", 16'($urandom_range(0, 255)), 1'b1, 16'($urandom_range(0, 255)),
           1'($urandom), 16'($urandom), 1'b1, 1'b0);
    look("stat_final", 16'h0000);
    check("s_branch_saturated", 32'(s_branch_count), 32'hF);
    check("s_mispredict_saturated", 32'(s_mispredict_count), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL take parameter PC_W, default 16: program-counter width in bits.
REQ-002 SHALL take parameter ENTRIES, default 16: table depth; power of two, minimum 2.
REQ-003 SHALL take parameter STAT_W, default 16: width of the statistics counters.
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-high; ports are named clk and rst.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- lookup_pc  in  PC_W  fetch-stage PC.
- hit  out  1  lookup_pc matches a valid entry.
- predict_taken  out  1  hit and the entry counter is in a taken state.
- predict_target  out  PC_W  stored target; 0 when not hit.
- update_valid  in  1  resolved branch from decode this cycle.
- update_pc  in  PC_W  PC of the resolved branch.
- update_taken  in  1  actual outcome.
- update_target  in  PC_W  actual target.
- update_mispredict  in  1  the earlier prediction was wrong.
- clear  in  1  invalidate all entries.
- branch_count  out  STAT_W  number of updates.
- mispredict_count  out  STAT_W  number of mispredicted updates.

Function
REQ-006 Index SHALL be pc[IDX_W:1], with IDX_W = log2(ENTRIES); pc[0] is ignored because instructions are 2-byte aligned.
REQ-007 Tag SHALL be pc[PC_W-1:IDX_W+1].
REQ-008 Each entry SHALL hold: valid, tag, target (PC_W bits), and a 2-bit counter.
REQ-009 Lookup SHALL be combinational from the registered table, giving a zero-cycle prediction.
REQ-010 There SHALL be no same-cycle bypass: a lookup sees the table contents from before that cycle's update.
REQ-011 Counter states: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken; predict_taken = hit & counter[1].
REQ-012 Update on a hit, with update_taken=1: counter increments, saturating at 11; target is overwritten with update_target.
REQ-013 Update on a hit, with update_taken=0: counter decrements, saturating at 00; target is unchanged.
REQ-014 Update on a miss, with update_taken=1: the entry is allocated or replaced (valid=1, new tag, target, counter=10).
REQ-015 Update on a miss, with update_taken=0: the table is unchanged.
REQ-016 All table writes SHALL take effect at the clock edge following update_valid.
REQ-017 clear SHALL reset every valid bit in one cycle and SHALL take priority over a simultaneous update.
REQ-018 Statistics SHALL still count an update that coincides with clear.
REQ-019 branch_count SHALL increment on each update_valid; mispredict_count SHALL increment on update_valid & update_mispredict.
REQ-020 Both statistics counters SHALL saturate at all-ones and never wrap.
REQ-021 Update inputs SHALL be ignored while update_valid=0.

Reset
REQ-022 rst SHALL asynchronously clear all valid bits, all counters to 01, all targets and tags to 0, and both statistics counters to 0.
REQ-023 Outputs during reset: hit=0, predict_taken=0, predict_target=0.
REQ-024 Reset asserted mid-update SHALL discard that update.
REQ-025 Operation SHALL resume on the first clock edge after rst deasserts.

Structure
REQ-026 A shared package bp_pkg SHALL hold the counter-state constants (SNT, WNT, WT, ST) and the weakly-taken allocation value.
REQ-027 One sub-module, bp_sat_counter, SHALL compute the combinational 2-bit saturating next state from (state, taken).
REQ-028 The table SHALL be flops, not inferred RAM, so that clear completes in one cycle.

Verification
REQ-029 After reset, lookup_pc=0x0040 SHALL give hit=0, predict_taken=0, predict_target=0x0000.
REQ-030 Update pc=0x0040, taken=1, target=0x0100; next cycle, lookup 0x0040 SHALL give hit=1, predict_taken=1, predict_target=0x0100.
REQ-031 Two not-taken updates to 0x0040 SHALL give predict_taken=0 with hit=1; three taken updates SHALL reach 11, and one not-taken update afterwards SHALL still predict taken.
REQ-032 Aliasing with ENTRIES=16: 0x0040, then update 0x0060 taken; lookup 0x0040 SHALL miss and 0x0060 SHALL hit.
REQ-033 Lookup and update of the same PC in the same cycle SHALL see the old value; clear together with an update SHALL leave the table empty while branch_count still increments.
REQ-034 With STAT_W=4, 20 updates with mispredict=1 SHALL leave both counters at 0xF.
